// File: rtl/tap_data_path_if.sv
// Bus between the TAP controller side and the JTAG register datapath.
interface tap_data_path_if #(
  parameter int unsigned IR_W  = 4,
  parameter int unsigned UDR_W = 8
);
  logic [3:0]       TAP_STATE;
  logic             TDI;
  logic [UDR_W-1:0] UDR_CAPTURE;
  logic             TDO;
  logic             TDO_EN;
  logic [IR_W-1:0]  IR_OUT;
  logic [UDR_W-1:0] UDR_OUT;
  logic             UDR_UPDATE;

  // Controller / core side: drives state, serial input and capture value.
  modport master (
    output TAP_STATE, TDI, UDR_CAPTURE,
    input  TDO, TDO_EN, IR_OUT, UDR_OUT, UDR_UPDATE
  );

  // Datapath side.
  modport slave (
    input  TAP_STATE, TDI, UDR_CAPTURE,
    output TDO, TDO_EN, IR_OUT, UDR_OUT, UDR_UPDATE
  );
endinterface

// File: rtl/tap_data_path.sv
// JTAG register datapath: IR, BYPASS, IDCODE and user DR, driven by the
// registered TAP state. TDO/TDO_EN launch on the falling edge of TCK.
module tap_data_path #(
  parameter int unsigned     IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
  parameter int unsigned     UDR_W      = 8,
  parameter logic [IR_W-1:0] INS_IDCODE = 4'b0001,
  parameter logic [IR_W-1:0] INS_USER   = 4'b0010,
  parameter logic [IR_W-1:0] INS_BYPASS = 4'b1111
) (
  input  logic               TCK,
  input  logic               TRST_N,
  tap_data_path_if.slave     bus
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  tap_state_e       w_state;
  logic             w_sel_id;
  logic             w_sel_usr;
  logic             w_sel_byp;
  logic             w_dr_tdo;

  logic [IR_W-1:0]  r_ir_sr;
  logic [IR_W-1:0]  r_ir_out;
  logic             r_bypass;
  logic [31:0]      r_id_sr;
  logic [UDR_W-1:0] r_udr_sr;
  logic [UDR_W-1:0] r_udr_out;
  logic             r_udr_upd;
  logic             r_tdo;
  logic             r_tdo_en;

  assign w_state = tap_state_e'(bus.TAP_STATE);

  // DR select decode; explicit BYPASS and every undefined opcode share BYPASS.
  // IR_OUT only moves in Update_IR/Test_Logic_Reset, so the selection is
  // stable across any DR scan.
  always_comb begin
    w_sel_id  = (r_ir_out == INS_IDCODE);
    w_sel_usr = (r_ir_out == INS_USER);
    w_sel_byp = (r_ir_out == INS_BYPASS) || !(w_sel_id || w_sel_usr);
  end

  // Serial output of the currently selected DR.
  always_comb begin
    w_dr_tdo = r_bypass;
    if (w_sel_id)       w_dr_tdo = r_id_sr[0];
    else if (w_sel_usr) w_dr_tdo = r_udr_sr[0];
  end

  // Instruction register: capture, shift, update, soft reset.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir_sr  <= '0;
      r_ir_out <= INS_IDCODE;
    end else begin
      case (w_state)
        TEST_LOGIC_RESET: r_ir_out <= INS_IDCODE;
        CAPTURE_IR:       r_ir_sr  <= IR_W'(2'b01);
        SHIFT_IR:         r_ir_sr  <= {bus.TDI, r_ir_sr[IR_W-1:1]};
        UPDATE_IR:        r_ir_out <= r_ir_sr;
        default:          ;
      endcase
    end
  end

  // Data registers: only the selected DR captures/shifts; user DR has an update stage.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_bypass  <= 1'b0;
      r_id_sr   <= '0;
      r_udr_sr  <= '0;
      r_udr_out <= '0;
      r_udr_upd <= 1'b0;
    end else begin
      r_udr_upd <= 1'b0;
      case (w_state)
        CAPTURE_DR: begin
          if (w_sel_id)       r_id_sr  <= IDCODE_VAL;
          else if (w_sel_usr) r_udr_sr <= bus.UDR_CAPTURE;
          else if (w_sel_byp) r_bypass <= 1'b0;
        end
        SHIFT_DR: begin
          if (w_sel_id)       r_id_sr  <= {bus.TDI, r_id_sr[31:1]};
          else if (w_sel_usr) r_udr_sr <= {bus.TDI, r_udr_sr[UDR_W-1:1]};
          else if (w_sel_byp) r_bypass <= bus.TDI;
        end
        UPDATE_DR: begin
          if (w_sel_usr) begin
            r_udr_out <= r_udr_sr;
            r_udr_upd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // TDO launch on the falling edge so it is stable at the next rising sample.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      case (w_state)
        SHIFT_IR: begin
          r_tdo    <= r_ir_sr[0];
          r_tdo_en <= 1'b1;
        end
        SHIFT_DR: begin
          r_tdo    <= w_dr_tdo;
          r_tdo_en <= 1'b1;
        end
        default: begin
          r_tdo    <= 1'b0;
          r_tdo_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TDO        = r_tdo;
  assign bus.TDO_EN     = r_tdo_en;
  assign bus.IR_OUT     = r_ir_out;
  assign bus.UDR_OUT    = r_udr_out;
  assign bus.UDR_UPDATE = r_udr_upd;

endmodule

// File: tb/tb_tap_data_path.sv
// Scoreboard bench for tap_data_path: stimulus pushes expected TDO bits and
// update values; a monitor on the falling edge pops and compares them.
module tb_tap_data_path;

  localparam int unsigned IR_W  = 4;
  localparam int unsigned UDR_W = 8;

  typedef enum logic [3:0] {
    TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3, SH_DR = 4'd4,
    EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7, UPD_DR = 4'd8,
    SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11, EX1_IR = 4'd12,
    PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } st_e;

  logic TCK;
  logic TRST_N;

  tap_data_path_if #(.IR_W(IR_W), .UDR_W(UDR_W)) bus ();

  tap_data_path #(
    .IR_W       (IR_W),
    .IDCODE_VAL (32'h1234_5001),
    .UDR_W      (UDR_W),
    .INS_IDCODE (4'b0001),
    .INS_USER   (4'b0010),
    .INS_BYPASS (4'b1111)
  ) dut (
    .TCK    (TCK),
    .TRST_N (TRST_N),
    .bus    (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit               exp_tdo[$];
  logic [UDR_W-1:0] exp_upd[$];

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: TDO stream and update strobe, sampled just after the falling edge.
  always @(negedge TCK) begin
    #1;
    if (bus.TDO_EN === 1'b1) begin
      if (exp_tdo.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL tdo_en_spurious: got TDO_EN=1 expected 0 at %0t", $time);
      end else begin
        chk("tdo_bit", {31'b0, bus.TDO}, {31'b0, exp_tdo.pop_front()});
      end
    end else begin
      chk("tdo_idle_zero", {31'b0, bus.TDO}, 32'd0);
    end
    if (bus.UDR_UPDATE === 1'b1) begin
      if (exp_upd.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL udr_update_spurious: got UDR_UPDATE=1 expected 0 at %0t", $time);
      end else begin
        chk("udr_out_at_update", {24'b0, bus.UDR_OUT}, {24'b0, exp_upd.pop_front()});
      end
    end
  end

  // One TCK cycle in state st; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input st_e st, input logic tdi);
    bus.TAP_STATE = st;
    bus.TDI       = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic cyc_sh(input st_e st, input logic tdi, input bit expb);
    exp_tdo.push_back(expb);
    cyc(st, tdi);
  endtask

  task automatic ir_scan(input logic [IR_W-1:0] tdi, input logic [IR_W-1:0] exp);
    cyc(SEL_DR, 1'b0);
    cyc(SEL_IR, 1'b0);
    cyc(CAP_IR, 1'b0);
    for (int i = 0; i < int'(IR_W); i++) cyc_sh(SH_IR, tdi[i], exp[i]);
    cyc(EX1_IR, 1'b0);
    cyc(UPD_IR, 1'b0);
    cyc(RTI, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] tdi, input logic [31:0] exp,
                         input bit upd, input logic [UDR_W-1:0] updv);
    cyc(SEL_DR, 1'b0);
    cyc(CAP_DR, 1'b0);
    for (int i = 0; i < n; i++) cyc_sh(SH_DR, tdi[i], exp[i]);
    cyc(EX1_DR, 1'b0);
    if (upd) exp_upd.push_back(updv);
    cyc(UPD_DR, 1'b0);
    cyc(RTI, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    TRST_N          = 1'b1;
    bus.TAP_STATE   = TLR;
    bus.TDI         = 1'b0;
    bus.UDR_CAPTURE = '0;
    #2 TRST_N = 1'b0;
    #1;
    chk("rst_tdo_en", {31'b0, bus.TDO_EN}, 32'd0);
    chk("rst_tdo", {31'b0, bus.TDO}, 32'd0);
    chk("rst_ir_out", {28'b0, bus.IR_OUT}, 32'h1);
    chk("rst_udr_out", {24'b0, bus.UDR_OUT}, 32'h0);
    chk("rst_udr_update", {31'b0, bus.UDR_UPDATE}, 32'd0);
    @(posedge TCK); @(posedge TCK); #1;
    TRST_N = 1'b1;
    cyc(TLR, 1'b0);
    cyc(RTI, 1'b0);

    // IDCODE readout, 32 bits LSB-first
    dr_scan(32, 32'h0, 32'h1234_5001, 1'b0, '0);

    // IR all ones: capture pattern 0001 out, BYPASS selected
    ir_scan(4'hF, 4'b0001);
    chk("ir_out_bypass", {28'b0, bus.IR_OUT}, 32'hF);
    // TDI 1,0,1,1,0 -> TDO 0,1,0,1,1
    dr_scan(5, 32'b01101, 32'b11010, 1'b0, '0);

    // user DR exchange
    ir_scan(4'b0010, 4'b0001);
    chk("ir_out_user", {28'b0, bus.IR_OUT}, 32'h2);
    bus.UDR_CAPTURE = 8'hA5;
    dr_scan(8, 32'h3C, 32'hA5, 1'b1, 8'h3C);
    chk("udr_out_3c", {24'b0, bus.UDR_OUT}, 32'h3C);
    chk("udr_update_low_after", {31'b0, bus.UDR_UPDATE}, 32'd0);

    // Pause in the middle of a user DR scan
    begin
      logic [7:0] cap, tdi;
      cap = 8'h5A; tdi = 8'hC3;
      bus.UDR_CAPTURE = cap;
      cyc(SEL_DR, 1'b0);
      cyc(CAP_DR, 1'b0);
      for (int i = 0; i < 3; i++) cyc_sh(SH_DR, tdi[i], cap[i]);
      cyc(EX1_DR, 1'b0);
      for (int i = 0; i < 5; i++) cyc(PAU_DR, 1'b1);
      cyc(EX2_DR, 1'b0);
      for (int i = 3; i < 8; i++) cyc_sh(SH_DR, tdi[i], cap[i]);
      cyc(EX1_DR, 1'b0);
      exp_upd.push_back(tdi);
      cyc(UPD_DR, 1'b0);
      cyc(RTI, 1'b0);
      chk("udr_out_pause", {24'b0, bus.UDR_OUT}, 32'hC3);
    end

    // Capture -> Exit1 with no shift: update applies the captured value
    bus.UDR_CAPTURE = 8'h96;
    dr_scan(0, 32'h0, 32'h0, 1'b1, 8'h96);
    chk("udr_out_noshift", {24'b0, bus.UDR_OUT}, 32'h96);

    // 12 shifts through the 8-bit user DR: TDI emerges after 8 bits
    bus.UDR_CAPTURE = 8'h81;
    dr_scan(12, 32'hABC, 32'hC81, 1'b1, 8'hAB);
    chk("udr_out_overshift", {24'b0, bus.UDR_OUT}, 32'hAB);

    // Undefined opcode behaves as BYPASS; TDI 1,1,0,1 -> TDO 0,1,1,0
    ir_scan(4'b0110, 4'b0001);
    chk("ir_out_undef", {28'b0, bus.IR_OUT}, 32'h6);
    dr_scan(4, 32'b1011, 32'b0110, 1'b0, '0);

    // Test_Logic_Reset: IR back to IDCODE, UDR_OUT held
    cyc(TLR, 1'b0);
    chk("tlr_ir_out", {28'b0, bus.IR_OUT}, 32'h1);
    chk("tlr_udr_hold", {24'b0, bus.UDR_OUT}, 32'hAB);
    cyc(RTI, 1'b0);
    dr_scan(8, 32'h0, 32'h01, 1'b0, '0);

    // Asynchronous reset in the middle of a user DR shift
    ir_scan(4'b0010, 4'b0001);
    bus.UDR_CAPTURE = 8'hFF;
    cyc(SEL_DR, 1'b0);
    cyc(CAP_DR, 1'b0);
    cyc_sh(SH_DR, 1'b0, 1'b1);
    cyc_sh(SH_DR, 1'b0, 1'b1);
    bus.TAP_STATE = SH_DR;
    chk("pre_reset_tdo_en", {31'b0, bus.TDO_EN}, 32'd1);
    TRST_N = 1'b0;
    #1;
    chk("mid_rst_tdo_en", {31'b0, bus.TDO_EN}, 32'd0);
    chk("mid_rst_tdo", {31'b0, bus.TDO}, 32'd0);
    chk("mid_rst_ir_out", {28'b0, bus.IR_OUT}, 32'h1);
    chk("mid_rst_udr_out", {24'b0, bus.UDR_OUT}, 32'h0);
    chk("mid_rst_udr_update", {31'b0, bus.UDR_UPDATE}, 32'd0);
    @(posedge TCK); #1;
    bus.TAP_STATE = TLR;
    TRST_N = 1'b1;
    cyc(TLR, 1'b0);
    cyc(RTI, 1'b0);

    chk("tdo_queue_drained", exp_tdo.size(), 32'd0);
    chk("upd_queue_drained", exp_upd.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
